// File: rtl/uart_frame_loader_if.sv
// Byte-stream and RAM-write bundle for uart_frame_loader.
//   rx_data/rx_valid : received byte and its 1-cycle strobe (into loader)
//   rx_gate          : receiver enable back to the UART (out of loader)
//   wr_en/addr/data  : sample-RAM write port (out of loader)
interface uart_frame_loader_if #(
  parameter int ADDR_W = 15
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_gate;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output rx_data, rx_valid, input rx_gate, wr_en, wr_addr, wr_data);
  modport slave  (input rx_data, rx_valid, output rx_gate, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/uart_frame_loader.sv
// Hunts framed packets (HDR, len, payload, checksum) in the UART byte stream and
// writes payload bytes to consecutive sample-RAM addresses starting at fill.
// A frame is committed (fill += len) only when its mod-256 checksum matches;
// any error leaves fill untouched so the next frame overwrites the same area.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          sync clear: fill = 0, abort frame, err_code kept
//   bus          rx byte in, rx_gate out, RAM write port out
//   fill         committed byte count; full = (fill == DEPTH)
//   busy         frame decode in progress
//   frame_ok     1-cycle commit pulse; frame_err 1-cycle reject pulse
//   err_code     last error: 1 checksum, 2 timeout, 3 bad length/overflow
module uart_frame_loader #(
  parameter int         ADDR_W  = 15,
  parameter logic [7:0] HDR     = 8'hA5,
  parameter int         MAX_LEN = 255,
  parameter int         TIMEOUT = 520800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  uart_frame_loader_if.slave bus,
  output logic [ADDR_W:0]   fill,
  output logic              full,
  output logic              busy,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [1:0]        err_code
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, SKIP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        len, len_nxt;
  logic [8:0]        cnt, cnt_nxt;     // bytes left in DATA or SKIP (SKIP can need 256)
  logic [ADDR_W-1:0] wptr, wptr_nxt;
  logic [7:0]        csum, csum_nxt;
  logic [TW-1:0]     tmr, tmr_nxt;
  logic [ADDR_W:0]   fill_nxt;
  logic [1:0]        err_nxt;
  logic              wr_en_q, wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
  logic [7:0]        wr_data_q, wr_data_nxt;
  logic              ok_nxt, bad_nxt;
  logic [31:0]       need;

  assign full         = (fill == (ADDR_W+1)'(DEPTH));
  assign busy         = (state != IDLE);
  assign bus.rx_gate  = !full;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  // Room check done once at LEN so wptr never runs past DEPTH-1 inside DATA.
  assign need         = 32'(fill) + 32'(bus.rx_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      wptr      <= '0;
      csum      <= '0;
      tmr       <= '0;
      fill      <= '0;
      err_code  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      cnt       <= cnt_nxt;
      wptr      <= wptr_nxt;
      csum      <= csum_nxt;
      tmr       <= tmr_nxt;
      fill      <= fill_nxt;
      err_code  <= err_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
      frame_ok  <= ok_nxt;
      frame_err <= bad_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    len_nxt     = len;
    cnt_nxt     = cnt;
    wptr_nxt    = wptr;
    csum_nxt    = csum;
    tmr_nxt     = tmr;
    fill_nxt    = fill;
    err_nxt     = err_code;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;
    ok_nxt      = 1'b0;
    bad_nxt     = 1'b0;

    if (clr) begin
      state_nxt = IDLE;
      fill_nxt  = '0;
      tmr_nxt   = '0;
    end else if (bus.rx_valid) begin
      // A byte always wins over a coincident timeout expiry.
      tmr_nxt = '0;
      case (state)
        IDLE: if (bus.rx_data == HDR) state_nxt = LEN;
        LEN: begin
          if (bus.rx_data == 8'd0) begin
            bad_nxt   = 1'b1;
            err_nxt   = 2'd3;
            state_nxt = IDLE;
          end else if (int'(bus.rx_data) > MAX_LEN || need > 32'(DEPTH)) begin
            bad_nxt   = 1'b1;
            err_nxt   = 2'd3;
            cnt_nxt   = {1'b0, bus.rx_data} + 9'd1;   // payload + checksum
            state_nxt = SKIP;
          end else begin
            len_nxt   = bus.rx_data;
            cnt_nxt   = {1'b0, bus.rx_data};
            wptr_nxt  = fill[ADDR_W-1:0];
            csum_nxt  = '0;
            state_nxt = DATA;
          end
        end
        DATA: begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = wptr;
          wr_data_nxt = bus.rx_data;
          wptr_nxt    = wptr + ADDR_W'(1);
          csum_nxt    = csum + bus.rx_data;
          cnt_nxt     = cnt - 9'd1;
          if (cnt == 9'd1) state_nxt = CSUM;
        end
        CSUM: begin
          if (bus.rx_data == csum) begin
            ok_nxt   = 1'b1;
            fill_nxt = fill + (ADDR_W+1)'(len);
          end else begin
            bad_nxt = 1'b1;
            err_nxt = 2'd1;
          end
          state_nxt = IDLE;
        end
        SKIP: begin
          cnt_nxt = cnt - 9'd1;
          if (cnt == 9'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (tmr == TW'(TIMEOUT)) begin
        tmr_nxt   = '0;
        state_nxt = IDLE;
        // An abandoned SKIP is not a new error; the length error was already flagged.
        if (state != SKIP) begin
          bad_nxt = 1'b1;
          err_nxt = 2'd2;
        end
      end else begin
        tmr_nxt = tmr + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_loader.sv
module tb_uart_frame_loader;
  localparam int         AW    = 4;
  localparam int         DEPTH = 16;
  localparam int         MAXL  = 10;
  localparam int         TMO   = 40;
  localparam logic [7:0] HDR   = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [AW:0]   fill;
  logic          full, busy, frame_ok, frame_err;
  logic [1:0]    err_code;

  uart_frame_loader_if #(.ADDR_W(AW)) bus();

  uart_frame_loader #(.ADDR_W(AW), .HDR(HDR), .MAX_LEN(MAXL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus),
    .fill(fill), .full(full), .busy(busy),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: frame assembled in a queue, judged from its contents.
  logic [7:0]  frm[$];
  int          skip_left = 0;
  int          m_fill = 0;
  int          m_err = 0;
  logic        exp_wr, exp_ok, exp_bad;
  logic [31:0] exp_addr, exp_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n, len, s;
    exp_wr = 0; exp_ok = 0; exp_bad = 0;
    if (skip_left > 0) skip_left--;
    else if (frm.size() == 0) begin
      if (b == HDR) frm.push_back(b);
    end else if (frm.size() == 1) begin
      if (b == 8'd0) begin
        exp_bad = 1; m_err = 3; frm.delete();
      end else if (int'(b) > MAXL || m_fill + int'(b) > DEPTH) begin
        exp_bad = 1; m_err = 3; frm.delete(); skip_left = int'(b) + 1;
      end else frm.push_back(b);
    end else begin
      n = frm.size() - 2;
      len = int'(frm[1]);
      if (n < len) begin
        exp_wr = 1; exp_addr = m_fill + n; exp_data = b; frm.push_back(b);
      end else begin
        s = 0;
        for (int i = 2; i < frm.size(); i++) s += int'(frm[i]);
        if (s % 256 == int'(b)) begin exp_ok = 1; m_fill += len; end
        else begin exp_bad = 1; m_err = 1; end
        frm.delete();
      end
    end
  endtask

  function automatic logic m_busy();
    return (frm.size() > 0) || (skip_left > 0);
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, " wr_en"}, bus.wr_en, exp_wr);
    if (exp_wr) begin
      chk({tag, " wr_addr"}, bus.wr_addr, exp_addr);
      chk({tag, " wr_data"}, bus.wr_data, exp_data);
    end
    chk({tag, " frame_ok"}, frame_ok, exp_ok);
    chk({tag, " frame_err"}, frame_err, exp_bad);
    chk({tag, " err_code"}, err_code, m_err);
    chk({tag, " fill"}, fill, m_fill);
    chk({tag, " full"}, full, m_fill == DEPTH);
    chk({tag, " rx_gate"}, bus.rx_gate, m_fill != DEPTH);
    chk({tag, " busy"}, busy, m_busy());
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b; bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    model_byte(b);
    check_outs("byte");
  endtask

  task automatic model_clr();
    frm.delete(); skip_left = 0; m_fill = 0;
    exp_wr = 0; exp_ok = 0; exp_bad = 0;
  endtask

  task automatic send_clr(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b; bus.rx_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0; clr = 1'b0;
    model_clr();
    check_outs("clr+byte");
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_clr();
    check_outs("clr");
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("gap quiet", {bus.wr_en, frame_ok, frame_err}, 0);
    end
  endtask

  task automatic silence();
    int seen, expn;
    seen = 0;
    expn = (frm.size() > 0) ? 1 : 0;
    repeat (2 * TMO) begin
      @(negedge clk);
      if (frame_err) seen++;
      chk("silence quiet", {bus.wr_en, frame_ok}, 0);
    end
    if (expn == 1) m_err = 2;
    frm.delete(); skip_left = 0;
    exp_wr = 0; exp_ok = 0; exp_bad = 0;
    chk("timeout pulses", seen, expn);
    check_outs("after silence");
  endtask

  task automatic send_seq(input bq_t q);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic frame(input int len, input bit bad_cs);
    logic [7:0] b;
    int s;
    s = 0;
    send(HDR);
    send(8'(len));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      s += int'(b);
      send(b);
      gap($urandom_range(0, 1));
    end
    send(8'(s + (bad_cs ? 1 : 0)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_wr = 0; exp_ok = 0; exp_bad = 0;
    check_outs("reset");
    rst_n = 1'b1;
    gap(2);

    // Basic good frame
    send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    chk("t1 fill", fill, 3);
    // Bad checksum, then a 1-byte frame at addr 3
    send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67});
    chk("t2 err_code", err_code, 1);
    chk("t2 fill", fill, 3);
    send_seq('{8'hA5, 8'h01, 8'h7F, 8'h7F});
    chk("t2 fill4", fill, 4);
    // Timeout mid-payload, then restart at the same address
    send_seq('{8'hA5, 8'h02, 8'h10});
    silence();
    chk("t3 err_code", err_code, 2);
    chk("t3 busy", busy, 0);
    frame(2, 0);
    chk("t3 fill", fill, 6);
    // Overflow with fill = 14, then exactly fill to DEPTH
    clr_pulse();
    frame(10, 0);
    frame(4, 0);
    chk("t4 fill14", fill, 14);
    send_seq('{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03});
    chk("t4 err_code", err_code, 3);
    chk("t4 skipping", busy, 1);
    send(8'h06);
    chk("t4 skip done", busy, 0);
    send_seq('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03});
    chk("t4 fill16", fill, 16);
    chk("t4 full", full, 1);
    chk("t4 rx_gate", bus.rx_gate, 0);
    frame(1, 0);
    chk("t4 full frame fill", fill, 16);
    // Length above MAX_LEN, and silence during SKIP
    clr_pulse();
    frame(11, 0);
    chk("maxlen err", err_code, 3);
    frame(2, 1);
    chk("cs err", err_code, 1);
    send_seq('{8'hA5, 8'h0C, 8'h01});
    silence();
    chk("skip silent err", err_code, 3);
    // Stray bytes then zero length
    frame(2, 1);
    send_seq('{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00});
    chk("t5 err_code", err_code, 3);
    chk("t5 busy", busy, 0);
    // clr on 2nd payload byte
    frame(3, 0);
    send_seq('{8'hA5, 8'h03, 8'h11});
    send_clr(8'h22);
    chk("t6 fill", fill, 0);
    chk("t6 wr_en", bus.wr_en, 0);
    send_seq('{8'hA5, 8'h01, 8'h42, 8'h42});
    chk("t6 fill1", fill, 1);
    // Async reset mid-frame, while wr_en is high
    send_seq('{8'hA5, 8'h03, 8'h11});
    rst_n = 1'b0;
    #1;
    chk("rst wr_en", bus.wr_en, 0);
    chk("rst fill", fill, 0);
    chk("rst busy", busy, 0);
    chk("rst err_code", err_code, 0);
    chk("rst rx_gate", bus.rx_gate, 1);
    frm.delete(); skip_left = 0; m_fill = 0; m_err = 0;
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 11);
      case (kind)
        0: clr_pulse();
        1: send_clr(8'($urandom));
        2: repeat ($urandom_range(1, 4)) send(8'($urandom));
        3: silence();
        4: frame($urandom_range(1, 6), 1);
        5: frame(0, 0);
        default: frame($urandom_range(1, 12), 0);
      endcase
      gap($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
